// File: rtl/decode_ctrl.sv
// ---------------------------------------------------------------------------
// decode_ctrl -- frame sequencer for a Viterbi-style decoder.
//
// Walks each frame through the phases below:
//   ACS  : accept one symbol pair per handshake and write survivors at 0..len-1
//   SEL  : start the minimum-metric search and wait SEL_LAT cycles for it
//   TB   : trace back through survivor memory from len-1 down to 0
//   WAIT : keep traceback enabled until the decoder reports completion
//   DONE : one-cycle frame-complete pulse
//
// Optional feature: define DECODE_TIMEOUT_EN to abort a frame after 1023
// consecutive ACS cycles with no input symbol (o_err pulse, no o_done).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_start         frame start request (only seen in IDLE)
//   i_frame_len     trellis steps in the frame, valid range 1..MAX_STEPS
//   i_in_valid      symbol pair available
//   o_in_ready      symbol pair accepted this cycle when i_in_valid is high
//   o_en_acs        add-compare-select / survivor write enable
//   o_wr_addr       survivor write address (step count)
//   o_en_sel        minimum-metric node-select enable (single pulse)
//   o_en_t          traceback enable
//   o_rd_addr       survivor read address
//   o_td_empty      final traceback step in progress
//   i_decoder_done  traceback complete (only seen in WAIT)
//   o_busy          frame in progress
//   o_done          frame-complete pulse
//   o_err           bad frame length or input-stall timeout pulse
// ---------------------------------------------------------------------------
module decode_ctrl #(
  parameter int MAX_STEPS = 96,
  parameter int SEL_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_frame_len,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_en_acs,
  output logic [7:0] o_wr_addr,
  output logic       o_en_sel,
  output logic       o_en_t,
  output logic [7:0] o_rd_addr,
  output logic       o_td_empty,
  input  logic       i_decoder_done,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int         SEL_W   = (SEL_LAT > 1) ? $clog2(SEL_LAT) : 1;
  localparam logic [8:0] MAX_LEN = 9'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_ACS, S_SEL, S_TB, S_WAIT, S_DONE
  } state_t;

  state_t             r_state, w_state_next;
  logic [7:0]         r_len;
  logic [7:0]         r_step;
  logic [7:0]         r_rd_addr;
  logic [SEL_W-1:0]   r_sel_cnt;
  logic               r_err;
  logic               w_len_ok;
  logic               w_timeout;

  assign w_len_ok = (i_frame_len != 8'd0) && ({1'b0, i_frame_len} <= MAX_LEN);

`ifdef DECODE_TIMEOUT_EN
  logic [9:0] r_stall;

  // Fires on the 1023rd consecutive idle ACS cycle, i.e. as the count hits 1023.
  assign w_timeout = (r_state == S_ACS) && !i_in_valid && (r_stall == 10'd1022);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (r_state != S_ACS || i_in_valid) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + 10'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_en_acs     = 1'b0;
    o_wr_addr    = 8'd0;
    o_en_sel     = 1'b0;
    o_en_t       = 1'b0;
    o_rd_addr    = 8'd0;
    o_td_empty   = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && w_len_ok) w_state_next = S_ACS;
      end
      S_ACS: begin
        o_in_ready = 1'b1;
        o_en_acs   = i_in_valid;
        o_wr_addr  = r_step;
        if (w_timeout) begin
          w_state_next = S_IDLE;
        end else if (i_in_valid && (r_step == r_len - 8'd1)) begin
          w_state_next = S_SEL;
        end
      end
      S_SEL: begin
        o_en_sel = (r_sel_cnt == '0);
        if (r_sel_cnt == SEL_W'(SEL_LAT - 1)) w_state_next = S_TB;
      end
      S_TB: begin
        o_en_t     = 1'b1;
        o_rd_addr  = r_rd_addr;
        o_td_empty = (r_rd_addr == 8'd0);
        if (r_rd_addr == 8'd0) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        o_en_t     = 1'b1;
        o_td_empty = 1'b1;
        if (i_decoder_done) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_err  = r_err;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; the asynchronous reset clears all of it,
  // including mid-frame, so no stale frame can complete after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= 8'd0;
      r_step    <= 8'd0;
      r_rd_addr <= 8'd0;
      r_sel_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_err     <= ((r_state == S_IDLE) && i_start && !w_len_ok) || w_timeout;
      r_sel_cnt <= (r_state == S_SEL) ? r_sel_cnt + 1'b1 : '0;
      case (r_state)
        S_IDLE: begin
          if (i_start && w_len_ok) begin
            r_len  <= i_frame_len;
            r_step <= 8'd0;
          end
        end
        S_ACS: begin
          if (i_in_valid) r_step <= r_step + 8'd1;
        end
        // Preload the traceback start while the node search is running.
        S_SEL: r_rd_addr <= r_len - 8'd1;
        S_TB: begin
          if (r_rd_addr != 8'd0) r_rd_addr <= r_rd_addr - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_ctrl -- directed/randomized bench for decode_ctrl.
// Each frame's expected timeline is derived from the frame length, the
// input-valid pattern and the decoder-done delay: len handshakes, SEL_LAT
// select cycles, len traceback cycles, the WAIT hold, then one DONE cycle.
// ---------------------------------------------------------------------------
module tb_decode_ctrl;

  localparam int MAX_STEPS = 96;
  localparam int SEL_LAT   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_frame_len;
  logic       i_in_valid;
  logic       o_in_ready;
  logic       o_en_acs;
  logic [7:0] o_wr_addr;
  logic       o_en_sel;
  logic       o_en_t;
  logic [7:0] o_rd_addr;
  logic       o_td_empty;
  logic       i_decoder_done;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  decode_ctrl #(.MAX_STEPS(MAX_STEPS), .SEL_LAT(SEL_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_frame_len    (i_frame_len),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .o_en_acs       (o_en_acs),
    .o_wr_addr      (o_wr_addr),
    .o_en_sel       (o_en_sel),
    .o_en_t         (o_en_t),
    .o_rd_addr      (o_rd_addr),
    .o_td_empty     (o_td_empty),
    .i_decoder_done (i_decoder_done),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] l, input logic v, input logic d);
    i_start        = s;
    i_frame_len    = l;
    i_in_valid     = v;
    i_decoder_done = d;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Random noise on inputs the DUT must ignore in the current phase.
  task automatic drive_noise(input logic d);
    drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   o_busy,     0);
    check({tag, "_ready"},  o_in_ready, 0);
    check({tag, "_acs"},    o_en_acs,   0);
    check({tag, "_wr"},     o_wr_addr,  0);
    check({tag, "_sel"},    o_en_sel,   0);
    check({tag, "_ent"},    o_en_t,     0);
    check({tag, "_rd"},     o_rd_addr,  0);
    check({tag, "_empty"},  o_td_empty, 0);
    check({tag, "_done"},   o_done,     0);
    check({tag, "_err"},    o_err,      0);
  endtask

  // gap: 0 = valid every cycle, >0 = that many idle cycles between valids,
  // -1 = random. abort_rd >= 0 asserts reset during TB at that read address.
  task automatic run_frame(input int len, input int gap, input int done_dly, input int abort_rd);
    int  accepted;
    int  idx;
    logic v;
    next_cycle();
    drive(1'b1, 8'(len), 1'b0, 1'b0);
    settle();
    check("start_busy", o_busy, 0);

    accepted = 0;
    idx      = 0;
    while (accepted < len && idx < 4000) begin
      next_cycle();
      if (gap == 0)     v = 1'b1;
      else if (gap > 0) v = (idx % (gap + 1)) == 0;
      else              v = ($urandom_range(0, 2) != 0);
      drive(1'($urandom_range(0, 1)), 8'($urandom), v, 1'($urandom_range(0, 1)));
      settle();
      check("acs_busy",  o_busy,     1);
      check("acs_ready", o_in_ready, 1);
      check("acs_en",    o_en_acs,   v);
      check("acs_wr",    o_wr_addr,  accepted);
      check("acs_sel",   o_en_sel,   0);
      check("acs_ent",   o_en_t,     0);
      check("acs_err",   o_err,      0);
      if (v) accepted++;
      idx++;
    end

    for (int k = 0; k < SEL_LAT; k++) begin
      next_cycle();
      drive_noise(1'($urandom_range(0, 1)));
      settle();
      check("sel_en",    o_en_sel,   (k == 0));
      check("sel_ready", o_in_ready, 0);
      check("sel_acs",   o_en_acs,   0);
      check("sel_ent",   o_en_t,     0);
      check("sel_busy",  o_busy,     1);
    end

    for (int k = 0; k < len; k++) begin
      next_cycle();
      drive_noise(1'($urandom_range(0, 1)));
      settle();
      check("tb_ent",   o_en_t,     1);
      check("tb_rd",    o_rd_addr,  len - 1 - k);
      check("tb_empty", o_td_empty, (k == len - 1));
      check("tb_ready", o_in_ready, 0);
      check("tb_done",  o_done,     0);
      if (len - 1 - k == abort_rd) begin
        rst = 1'b1;
        #1;
        check_zero("rst_now");
        next_cycle();
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        settle();
        check_zero("rst_hold");
        next_cycle();
        rst = 1'b0;
        return;
      end
    end

    for (int k = 0; k < done_dly; k++) begin
      next_cycle();
      drive_noise(1'b0);
      settle();
      check("wait_ent",   o_en_t,     1);
      check("wait_empty", o_td_empty, 1);
      check("wait_done",  o_done,     0);
      check("wait_busy",  o_busy,     1);
    end
    next_cycle();
    drive_noise(1'b1);
    settle();
    check("wait_last_ent",  o_en_t, 1);
    check("wait_last_done", o_done, 0);

    next_cycle();
    drive_noise(1'($urandom_range(0, 1)));
    settle();
    check("done_pulse", o_done, 1);
    check("done_ent",   o_en_t, 0);
    check("done_busy",  o_busy, 1);

    next_cycle();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    settle();
    check("end_busy", o_busy, 0);
    check("end_done", o_done, 0);
    check("end_err",  o_err,  0);
  endtask

  task automatic bad_len(input int len);
    next_cycle();
    drive(1'b1, 8'(len), 1'b0, 1'b0);
    settle();
    check("bad_busy0", o_busy, 0);
    check("bad_err0",  o_err,  0);
    next_cycle();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    settle();
    check("bad_err1",  o_err,  1);
    check("bad_busy1", o_busy, 0);
    next_cycle();
    settle();
    check("bad_err2",  o_err,  0);
    check("bad_busy2", o_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    #12;
    check_zero("reset");
    next_cycle();
    rst = 1'b0;

    run_frame(MAX_STEPS, 0, 0, -1);   // full-length frame, valid held high
    run_frame(4, 3, 0, -1);           // sparse input
    bad_len(0);
    bad_len(200);
    bad_len(MAX_STEPS + 1);
    run_frame(7, -1, 5, -1);          // delayed decoder completion
    run_frame(MAX_STEPS, -1, 1, 40);  // reset mid-traceback
    run_frame(1, 0, 2, -1);           // single-step frame after reset
    for (int n = 0; n < 4; n++) begin
      run_frame($urandom_range(1, 20), -1, $urandom_range(0, 4), -1);
    end

`ifdef DECODE_TIMEOUT_EN
    next_cycle();
    drive(1'b1, 8'd5, 1'b0, 1'b0);
    for (int k = 0; k < 1023; k++) begin
      next_cycle();
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      settle();
      if (k == 0 || k == 1022) check("to_ready", o_in_ready, 1);
    end
    next_cycle();
    settle();
    check("to_err",  o_err,  1);
    check("to_busy", o_busy, 0);
    check("to_done", o_done, 0);
    next_cycle();
    settle();
    check("to_err_end", o_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
